// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg : shared types and constants for the line-granular dmem.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package dmem_pkg;

   localparam int LINE_W   = 256;
   localparam int OFFSET_W = 5;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;
   localparam logic [1:0] TURN = 2'd3;

   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_line_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_line_array : DEPTH x 256-bit line store, sync write, comb read. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dmem_line_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int IDX_W = idx_w(DEPTH)
) (
   input  logic              clk_i,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] o_rdata
);

   logic [LINE_W-1:0] r_mem [DEPTH];

   // No reset: line contents survive a responder reset.
   always_ff @(posedge clk_i) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/dmem_line_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_line_responder : fixed-latency line read/write slave for L1 D$. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dmem_line_responder
   import dmem_pkg::*;
#(
   parameter int LATENCY = 10,
   parameter int DEPTH   = 512,
   parameter int ADDR_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mem_enable_i,
   input  logic              mem_write_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [LINE_W-1:0] mem_data_i,
   output logic [LINE_W-1:0] mem_data_o,
   output logic              mem_ack_o
);

   localparam int IDX_W = idx_w(DEPTH);
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] c_lat = CNT_W'(LATENCY);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_write;
   logic [IDX_W-1:0]  r_idx;
   logic [LINE_W-1:0] r_wdata;
   logic              r_ack;
   logic [LINE_W-1:0] r_rdata;
   logic [LINE_W-1:0] w_rdata;
   logic              w_accept;
   logic              w_done;
   logic              w_we;
   logic              w_rd_load;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_done;
         if (w_accept) begin
            r_write <= mem_write_i;
            r_idx   <= mem_addr_i[OFFSET_W +: IDX_W];
            r_wdata <= mem_data_i;
            r_cnt   <= CNT_W'(1);
         end else if (w_done) begin
            r_cnt <= '0;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_rd_load) begin
            r_rdata <= w_rdata;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (mem_enable_i) w_state_nxt = BUSY;
         BUSY:    if (r_cnt == c_lat) w_state_nxt = ACK;
         ACK:     w_state_nxt = TURN;
         TURN:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_accept  = (r_state == IDLE) && mem_enable_i;
      w_done    = (r_state == BUSY) && (r_cnt == c_lat);
      w_we      = w_done && r_write;
      w_rd_load = w_done && !r_write;
   end

   dmem_line_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk_i   (clk_i),
      .i_we    (w_we),
      .i_idx   (r_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_rdata)
   );

   assign mem_data_o = r_rdata;
   assign mem_ack_o  = r_ack;

   // Line offset and bits above the index are don't-care (addresses alias).
   logic w_unused_lo;
   assign w_unused_lo = ^mem_addr_i[OFFSET_W-1:0];

   generate
      if (ADDR_W > OFFSET_W + IDX_W) begin : g_addr_hi
         logic w_unused_hi;
         assign w_unused_hi = ^mem_addr_i[ADDR_W-1:OFFSET_W+IDX_W];
      end
   endgenerate

endmodule
`default_nettype wire
